// File: rtl/explosion_controller.sv
// Explosion sprite controller: a small pool of animated explosion slots plus a
// two-stage pixel pipeline that looks up the winning slot's sprite in an external ROM.
module explosion_controller #(
  parameter int         NUM_SLOTS   = 4,
  parameter int         NUM_FRAMES  = 8,
  parameter int         FRAME_HOLD  = 4,
  parameter logic [3:0] TRANSPARENT = 4'h1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        trigger,
  input  logic [9:0]  trig_x,
  input  logic [9:0]  trig_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [12:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        expl_on,
  output logic [3:0]  expl_index,
  output logic        full,
  output logic [2:0]  active_count,
  output logic        expl_done
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [2:0]    FRAME_LAST = 3'(NUM_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(FRAME_HOLD - 1);

  typedef enum logic {
    SLOT_IDLE   = 1'b0,
    SLOT_ACTIVE = 1'b1
  } slot_state_e;

  typedef struct packed {
    slot_state_e   state;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [2:0]    frame;
    logic [HW-1:0] hold;
  } slot_t;

  slot_t slot_q [NUM_SLOTS];
  slot_t slot_d [NUM_SLOTS];

  logic          done_d, done_q;
  logic [2:0]    count;
  logic          free_found;
  logic [SW-1:0] free_idx;
  logic          alloc_en;

  logic          hit;
  logic [2:0]    win_frame;
  logic [4:0]    win_row;
  logic [4:0]    win_col;

  logic [12:0]   rom_addr_q;
  logic          hit_q;
  logic          expl_on_q;
  logic [3:0]    expl_index_q;

  // 11-bit compare so a sprite near the right/bottom edge never wraps to column/row 0.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] base);
    return ({1'b0, pos} >= {1'b0, base}) && ({1'b0, pos} < ({1'b0, base} + 11'd32));
  endfunction

  // Occupancy is taken from registered state only, so a slot retiring this
  // cycle still counts as busy and cannot be reallocated until the next one.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch; a path
    // that leaves a signal unassigned would infer a latch.
    count      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q[i].state == SLOT_ACTIVE) begin
        count = count + 3'd1;
      end else if (!free_found) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
  end

  assign alloc_en = trigger && free_found;

  always_comb begin
    done_d = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
      if (frame_tick && slot_q[i].state == SLOT_ACTIVE) begin
        if (slot_q[i].hold == HOLD_LAST) begin
          slot_d[i].hold = '0;
          if (slot_q[i].frame == FRAME_LAST) begin
            slot_d[i].state = SLOT_IDLE;
            slot_d[i].frame = '0;
            done_d          = 1'b1;
          end else begin
            slot_d[i].frame = slot_q[i].frame + 3'd1;
          end
        end else begin
          slot_d[i].hold = slot_q[i].hold + 1'b1;
        end
      end
    end
    // The chosen slot is idle, so the tick above never touched it: it starts at 0/0.
    if (alloc_en) begin
      slot_d[free_idx] = '{state: SLOT_ACTIVE, x: trig_x, y: trig_y, frame: '0, hold: '0};
    end
  end

  // NOTE: the slot array is real state that gates allocation, so every entry is
  // reset; unlike a data RAM, leaving it unreset would make the pool X after power-up.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '{state: SLOT_IDLE, x: '0, y: '0, frame: '0, hold: '0};
      end
      done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from pre-edge values.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      done_q <= done_d;
    end
  end

  // Lowest-numbered active slot covering the current pixel wins.
  always_comb begin
    hit       = 1'b0;
    win_frame = '0;
    win_row   = '0;
    win_col   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit && slot_q[i].state == SLOT_ACTIVE &&
          in_span(DrawX, slot_q[i].x) && in_span(DrawY, slot_q[i].y)) begin
        hit       = 1'b1;
        win_frame = slot_q[i].frame;
        win_row   = DrawY[4:0] - slot_q[i].y[4:0];
        win_col   = DrawX[4:0] - slot_q[i].x[4:0];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q   <= '0;
      hit_q        <= 1'b0;
      expl_on_q    <= 1'b0;
      expl_index_q <= '0;
    end else begin
      rom_addr_q   <= hit ? {win_frame, win_row, win_col} : 13'd0;
      hit_q        <= hit;
      expl_on_q    <= hit_q && (rom_data != TRANSPARENT);
      expl_index_q <= rom_data;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign expl_on      = expl_on_q;
  assign expl_index   = expl_index_q;
  assign expl_done    = done_q;
  assign active_count = count;
  assign full         = (count == 3'(NUM_SLOTS));

endmodule
